demux1x4_collector: RTL and testbench

- Receive end of the 4:1 select path: accepts a time-multiplexed single-lane stream and steers each accepted word to one of four channel registers (a, b, c, d).
- Select comes either from an explicit `sel` or from an internal round-robin pointer.
- Once all four channels have been written, it presents them as one packed frame with a valid/ready handshake to the downstream power-estimation logic.
- Also emits per-channel one-cycle write strobes.

---
 rtl/demux1x4_collector.sv | 143 ++++++++++++++
 tb/tb_demux1x4_collector.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/demux1x4_collector.sv
// Receive side of the 4:1 select path. Steers a single-lane word stream into
// four channel registers and hands completed {d,c,b,a} frames downstream.

module demux1x4_collector_lane #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] q,
    output logic              strobe
);

    always_ff @(posedge clk) begin
        if (rst) begin
            q      <= '0;
            strobe <= 1'b0;
        end else begin
            strobe <= wr;
            if (wr)
                q <= din;
        end
    end

endmodule

module demux1x4_collector #(
    parameter int DATA_W = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_W-1:0]     in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [1:0]            sel,
    input  logic                  auto_en,
    output logic [DATA_W-1:0]     out_a,
    output logic [DATA_W-1:0]     out_b,
    output logic [DATA_W-1:0]     out_c,
    output logic [DATA_W-1:0]     out_d,
    output logic [3:0]            ch_strobe,
    output logic [4*DATA_W-1:0]   frame_data,
    output logic                  frame_valid,
    input  logic                  frame_ready,
    output logic                  dup_err
);

    typedef enum logic {COLLECT, HOLD} state_t;

    state_t                   state, state_nx;
    logic [1:0]               ptr, dst;
    logic                     accept;
    logic [3:0]               dst_oh, wr_en;
    logic [3:0]               mask, mask_nx;
    logic                     fv_nx, load_frame;
    logic [3:0][DATA_W-1:0]   chan, chan_nx;

    assign dst    = auto_en ? ptr : sel;
    assign dst_oh = 4'b0001 << dst;
    assign accept = in_valid && in_ready;
    assign wr_en  = accept ? dst_oh : 4'b0000;

    genvar i;
    generate
        for (i = 0; i < 4; i++) begin : g_lane
            demux1x4_collector_lane #(.DATA_W(DATA_W)) u_lane (
                .clk    (clk),
                .rst    (rst),
                .wr     (wr_en[i]),
                .din    (in_data),
                .q      (chan[i]),
                .strobe (ch_strobe[i])
            );
            // Frame snapshot must include the word landing on this same edge.
            assign chan_nx[i] = wr_en[i] ? in_data : chan[i];
        end
    endgenerate

    assign out_a = chan[0];
    assign out_b = chan[1];
    assign out_c = chan[2];
    assign out_d = chan[3];

    always_comb begin
        state_nx   = state;
        mask_nx    = mask;
        fv_nx      = frame_valid;
        load_frame = 1'b0;
        in_ready   = 1'b1;
        case (state)
            COLLECT: begin
                in_ready = 1'b1;
                if (accept) begin
                    if ((mask | dst_oh) == 4'b1111) begin
                        load_frame = 1'b1;
                        fv_nx      = 1'b1;
                        mask_nx    = 4'b0000;
                        state_nx   = HOLD;
                    end else begin
                        mask_nx = mask | dst_oh;
                    end
                end
            end
            HOLD: begin
                // A word taken on the release cycle opens the next frame.
                in_ready = frame_ready;
                if (frame_ready) begin
                    fv_nx    = 1'b0;
                    state_nx = COLLECT;
                    mask_nx  = accept ? dst_oh : 4'b0000;
                end
            end
            default: begin
                state_nx = COLLECT;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= COLLECT;
            mask        <= '0;
            ptr         <= '0;
            frame_valid <= 1'b0;
            frame_data  <= '0;
            dup_err     <= 1'b0;
        end else begin
            state       <= state_nx;
            mask        <= mask_nx;
            frame_valid <= fv_nx;
            if (load_frame)
                frame_data <= chan_nx;
            if (accept && |(mask & dst_oh))
                dup_err <= 1'b1;
            if (!auto_en)
                ptr <= '0;
            else if (accept)
                ptr <= ptr + 2'd1;
        end
    end

endmodule

// File: tb/tb_demux1x4_collector.sv
// Randomized + directed bench for demux1x4_collector with a transaction-level
// reference model and a frame scoreboard checked on the falling edge.

module tb_demux1x4_collector;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  sel;
    logic        auto_en;
    logic [7:0]  out_a, out_b, out_c, out_d;
    logic [3:0]  ch_strobe;
    logic [31:0] frame_data;
    logic        frame_valid;
    logic        frame_ready;
    logic        dup_err;

    demux1x4_collector #(.DATA_W(8)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_data     (in_data),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .sel         (sel),
        .auto_en     (auto_en),
        .out_a       (out_a),
        .out_b       (out_b),
        .out_c       (out_c),
        .out_d       (out_d),
        .ch_strobe   (ch_strobe),
        .frame_data  (frame_data),
        .frame_valid (frame_valid),
        .frame_ready (frame_ready),
        .dup_err     (dup_err)
    );

    always #5 clk = ~clk;

    // Reference model: channel contents, which channels this frame has seen,
    // whether a finished frame is waiting, and the round-robin slot.
    logic [7:0]  mch [4];
    logic [3:0]  m_written;
    logic        m_pend;
    logic        m_dup;
    logic [1:0]  m_ptr;
    logic [3:0]  m_strobe;
    logic [31:0] fq [$];

    int  n_chk  = 0;
    int  n_fail = 0;
    bit  started = 1'b0;
    bit  done    = 1'b0;

    task automatic model_reset();
        for (int k = 0; k < 4; k++) mch[k] = 8'h00;
        m_written = 4'b0000;
        m_pend    = 1'b0;
        m_dup     = 1'b0;
        m_ptr     = 2'd0;
        m_strobe  = 4'b0000;
        fq.delete();
    endtask

    task automatic model_step(input logic iv, input logic [7:0] d, input logic [1:0] s,
                              input logic a, input logic fr);
        logic       rdy, acc;
        logic [1:0] ch;
        rdy = !m_pend || fr;
        acc = iv && rdy;
        m_strobe = 4'b0000;
        if (m_pend && fr) m_pend = 1'b0;
        if (acc) begin
            ch = a ? m_ptr : s;
            if (m_written[ch]) m_dup = 1'b1;
            mch[ch] = d;
            m_written[ch] = 1'b1;
            m_strobe[ch] = 1'b1;
            if (m_written == 4'b1111) begin
                fq.push_back({mch[3], mch[2], mch[1], mch[0]});
                m_written = 4'b0000;
                m_pend    = 1'b1;
            end
        end
        if (!a) m_ptr = 2'd0;
        else if (acc) m_ptr = m_ptr + 2'd1;
    endtask

    task automatic tick(input logic iv, input logic [7:0] d, input logic [1:0] s,
                        input logic a, input logic fr);
        in_valid = iv; in_data = d; sel = s; auto_en = a; frame_ready = fr;
        @(posedge clk);
        model_step(iv, d, s, a, fr);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; in_valid = 1'b0; frame_ready = 1'b0;
        @(posedge clk);
        model_reset();
        #1;
        rst = 1'b0;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (started && !rst) begin
            chk("in_ready", 64'(in_ready), 64'(!m_pend || frame_ready));
            chk("out_a", 64'(out_a), 64'(mch[0]));
            chk("out_b", 64'(out_b), 64'(mch[1]));
            chk("out_c", 64'(out_c), 64'(mch[2]));
            chk("out_d", 64'(out_d), 64'(mch[3]));
            chk("ch_strobe", 64'(ch_strobe), 64'(m_strobe));
            chk("dup_err", 64'(dup_err), 64'(m_dup));
            chk("frame_valid", 64'(frame_valid), 64'(m_pend));
            if (frame_valid && fq.size() > 0) begin
                chk("frame_data", 64'(frame_data), 64'(fq[0]));
                if (frame_ready) void'(fq.pop_front());
            end
            if (done) begin
                chk("frames_left", 64'(fq.size()), 64'd0);
                $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
                $finish;
            end
        end
    end

    initial begin
        in_valid = 1'b0; in_data = 8'h00; sel = 2'd0; auto_en = 1'b0; frame_ready = 1'b0;
        model_reset();
        rst = 1'b1;
        @(posedge clk);
        do_reset();
        started = 1'b1;

        // explicit select
        tick(1, 8'h11, 0, 0, 1);
        tick(1, 8'h22, 1, 0, 1);
        tick(1, 8'h33, 2, 0, 1);
        tick(1, 8'h44, 3, 0, 1);
        tick(0, 8'h00, 0, 0, 1);

        // round-robin, two frames back to back
        for (int k = 1; k <= 8; k++) tick(1, 8'(k), 0, 1, 1);
        tick(0, 8'h00, 0, 1, 1);

        // backpressure with a word arriving on the release cycle
        for (int k = 0; k < 4; k++) tick(1, 8'h60 + 8'(k), 2'(k), 0, 0);
        for (int k = 0; k < 5; k++) tick(1, 8'hE0 + 8'(k), 2'(k), 0, 0);
        tick(1, 8'hAA, 2, 0, 1);
        tick(1, 8'hBA, 0, 0, 1);
        tick(1, 8'hBB, 1, 0, 1);
        tick(1, 8'hBD, 3, 0, 1);
        tick(0, 8'h00, 0, 0, 1);

        // duplicate write
        do_reset();
        tick(1, 8'h10, 0, 0, 1);
        tick(1, 8'h20, 0, 0, 1);
        tick(1, 8'h30, 1, 0, 1);
        tick(1, 8'h40, 2, 0, 1);
        tick(1, 8'h50, 3, 0, 1);
        tick(0, 8'h00, 0, 0, 1);

        // reset mid-frame
        tick(1, 8'h77, 0, 0, 1);
        tick(1, 8'h78, 1, 0, 1);
        do_reset();
        for (int k = 0; k < 4; k++) tick(1, 8'hA0 + 8'(k), 2'(k), 0, 1);
        tick(0, 8'h00, 0, 0, 1);

        // mode switch mid-frame, then auto again restarts at channel a
        tick(1, 8'hC0, 3, 1, 1);
        tick(1, 8'hC1, 3, 1, 1);
        tick(1, 8'hC2, 2, 0, 1);
        tick(1, 8'hC3, 3, 0, 1);
        for (int k = 0; k < 4; k++) tick(1, 8'hD0 + 8'(k), 3, 1, 1);
        tick(0, 8'h00, 0, 1, 1);

        // randomized traffic
        begin
            logic a;
            a = 1'b0;
            for (int k = 0; k < 600; k++) begin
                if ($urandom_range(0, 15) == 0) a = ~a;
                if ($urandom_range(0, 249) == 0) do_reset();
                tick($urandom_range(0, 3) != 0, 8'($urandom), 2'($urandom),
                     a, $urandom_range(0, 2) != 0);
            end
        end

        for (int k = 0; k < 4; k++) tick(0, 8'h00, 0, 0, 1);
        done = 1'b1;
    end

endmodule
